// File: rtl/alu_pkg.sv
// Shared ALU/MDU definitions: M-group op codes, sequencer states and op-class predicates.
package alu_pkg;

  localparam logic [4:0] ALU_MUL    = 5'ha;
  localparam logic [4:0] ALU_MULH   = 5'hb;
  localparam logic [4:0] ALU_MULHSU = 5'hc;
  localparam logic [4:0] ALU_MULHU  = 5'hd;
  localparam logic [4:0] ALU_DIV    = 5'he;
  localparam logic [4:0] ALU_DIVU   = 5'hf;
  localparam logic [4:0] ALU_REM    = 5'h10;
  localparam logic [4:0] ALU_REMU   = 5'h11;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the magnitude datapath: radix-2 shift-add multiply or restoring divide.
module mdu_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    addend  = lo_i[0] ? opnd_i : '0;
    sum     = {1'b0, hi_i} + {1'b0, addend};
    // Partial remainder shifted left with the next dividend bit; needs the extra top bit.
    shifted = {hi_i, lo_i[XLEN-1]};
    ge      = shifted >= {1'b0, opnd_i};
    if (is_div_i) begin
      hi_o = ge ? (shifted[XLEN-1:0] - opnd_i) : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide unit: 32 magnitude iterations, then a sign/select fix-up cycle.
module mdu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            sign_q, sign_d;
  logic            bzero_q, bzero_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              op_div;

  assign op_div = is_div_op(op_q);

  mdu_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div_i(op_div),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .opnd_i  (opnd_q),
    .hi_o    (step_hi),
    .lo_o    (step_lo)
  );

  always_comb begin
    accept   = start && is_mdu_op(aluControl) && ((state_q == IDLE) || (state_q == DONE));
    a_neg    = is_signed_a(aluControl) && A[XLEN-1];
    b_neg    = is_signed_b(aluControl) && B[XLEN-1];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    prod_fix = sign_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = sign_q ? -lo_q : lo_q;
    rem_fix  = sign_q ? -hi_q : hi_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    sign_d   = sign_q;
    bzero_d  = bzero_q;
    result_d = result_q;

    case (state_q)
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        cnt_d   = '0;
        case (op_q)
          ALU_MUL:                          result_d = prod_fix[XLEN-1:0];
          ALU_MULH, ALU_MULHSU, ALU_MULHU:  result_d = prod_fix[2*XLEN-1:XLEN];
          ALU_DIV, ALU_DIVU:                result_d = bzero_q ? '1 : quo_fix;
          ALU_REM, ALU_REMU:                result_d = bzero_q ? a_q : rem_fix;
          default:                          result_d = result_q;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Multiply keeps the multiplier in lo and adds into hi; divide shifts the dividend out of lo.
    if (accept) begin
      state_d = CALC;
      cnt_d   = '0;
      op_d    = aluControl;
      a_d     = A;
      bzero_d = (B == '0);
      hi_d    = '0;
      if (is_div_op(aluControl)) begin
        lo_d   = a_mag;
        opnd_d = b_mag;
        sign_d = is_rem_op(aluControl) ? a_neg : (a_neg ^ b_neg);
      end else begin
        lo_d   = b_mag;
        opnd_d = a_mag;
        sign_d = a_neg ^ b_neg;
      end
    end

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_q == FIX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      sign_q   <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      sign_q   <= sign_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/mdu_seq.md
# mdu_seq

- Multi-cycle RISC-V M-extension unit.
- Takes the M-group operation codes and operands that the single-cycle ALU otherwise evaluates combinationally.
- Computes the result over 32 iterations behind a start/busy/done handshake.
- Sits beside the ALU; the control path stalls the core while `busy` is high and writes back `result` on `done`.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request strobe, sampled on a rising edge
- aluControl  in  5  operation code (M group 5'ha..5'h11, same encoding as the ALU)
- A  in  32  operand rs1
- B  in  32  operand rs2
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result valid
- result  out  32  final result, held until the next done

## Operation
- Op codes:
  - 5'ha mul (low 32)
  - 5'hb mulh (s×s, high 32)
  - 5'hc mulhsu (A signed × B unsigned, high 32)
  - 5'hd mulhu (high 32)
  - 5'he div
  - 5'hf divu
  - 5'h10 rem
  - 5'h11 remu
- Acceptance: `start` is accepted only in IDLE or DONE with `aluControl` in 5'ha..5'h11.
  - A, B and the code are latched on the accepting edge.
  - Any other code is ignored.
  - `start` in CALC or FIX is ignored.
- FSM: IDLE -> CALC (accept) -> FIX (iteration counter = 31) -> DONE -> IDLE, or DONE -> CALC on an accepted start.
- Magnitude datapath: latch |A| and |B| per signedness; record the result sign.
  - Multiply: sign = sA^sB (sB = 0 for mulhsu/mulhu).
  - Quotient: sign = sA^sB.
  - Remainder: sign = sA.
- Multiply: radix-2 shift-add over a 64-bit accumulator, one bit of B per CALC cycle.
- Divide: restoring, one quotient bit per CALC cycle; 33-bit partial remainder.
- FIX: two's-complement negates when the sign is set, selects the high or low half, and registers `result`.
- Divide by zero overrides the normal result in FIX:
  - quotient = 32'hFFFFFFFF (div and divu)
  - remainder = A
- Signed overflow (A = 32'h80000000, B = 32'hFFFFFFFF) needs no override; the magnitude path already yields:
  - quotient 32'h80000000
  - remainder 0

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0. Asynchronous reset aborts any operation immediately and no done follows.
- Accepting edge E:
  - busy = 1 from E through E+33.
  - CALC iterates on edges E+1..E+32.
  - FIX registers result on E+33.
  - done = 1 for exactly the cycle after E+33, with busy = 0 in that cycle.
  - Latency is 33 cycles for every op, including divide by zero.
- done is never high for two consecutive cycles unless back-to-back starts are accepted in DONE.
- A start accepted in DONE begins a new op: busy rises next cycle and `result` keeps the old value until the new FIX.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg`:
  - op code constants ALU_MUL..ALU_REMU (5'ha..5'h11)
  - FSM state enum {IDLE, CALC, FIX, DONE}
  - helper predicates is_mdu_op, is_div_op, is_signed_a, is_signed_b
- One sub-module is natural: `mdu_step`, combinational, one shift-add / restore-subtract iteration, instantiated once.
- Control, latching and FIX logic stay in `mdu_seq`.

## Test plan
- mul, A = 7, B = 32'hFFFFFFFD -> result 32'hFFFFFFEB; done exactly 34 cycles after the accepting edge.
- High-half multiplies:
  - mulh 32'h80000000 × 32'h80000000 -> 32'h40000000
  - mulhu 32'hFFFFFFFF × 32'hFFFFFFFF -> 32'hFFFFFFFE
  - mulhsu 32'hFFFFFFFF × 32'hFFFFFFFF -> 32'hFFFFFFFF
- Signed divide:
  - div -7/2 -> 32'hFFFFFFFD
  - rem -7%2 -> 32'hFFFFFFFF
  - divu 100/7 -> 14
  - remu 100%7 -> 2
- Corner cases:
  - div 5/0 -> 32'hFFFFFFFF
  - rem 5%0 -> 5
  - divu 32'hFFFFFFFF/0 -> 32'hFFFFFFFF
  - div 32'h80000000/-1 -> 32'h80000000
  - rem 32'h80000000%-1 -> 0
- Handshake:
  - start with code 5'h0 -> busy stays 0.
  - start pulsed mid-CALC -> ignored, single done.
  - start held in the DONE cycle -> second op accepted, second done 34 cycles later.
- reset asserted 10 cycles into a div -> busy 0, done 0, result 0 immediately; no done pulse afterwards.
